instr_fetch_buffer: RTL and testbench

//  Two-entry skid buffer between instruction memory and decode. Holds

---
 rtl/instr_fetch_buffer.sv | 110 +++++++++++
 tb/tb_instr_fetch_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_buffer.sv
// Two-entry skid buffer between instruction fetch and decode.
// Carries each instruction with its PC and splits the head word into opcode, register select and immediate.
module instr_fetch_buffer #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 16,
    parameter int IMM_W   = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [5:0]         out_opcode,
    output logic               out_reg_sel,
    output logic [IMM_W-1:0]   out_immed,
    output logic [PC_W-1:0]    out_pc
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               inReady_q, inReady_d;
    logic [INSTR_W-1:0] headInstr_q, headInstr_d;
    logic [PC_W-1:0]    headPc_q, headPc_d;
    logic [INSTR_W-1:0] skidInstr_q, skidInstr_d;
    logic [PC_W-1:0]    skidPc_q, skidPc_d;
    logic               pushFire;
    logic               popFire;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = inReady_q;
    assign pushFire  = in_valid & inReady_q;
    assign popFire   = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        headInstr_d = headInstr_q;
        headPc_d    = headPc_q;
        skidInstr_d = skidInstr_q;
        skidPc_d    = skidPc_q;
        case (state_q)
            EMPTY: begin
                if (pushFire) begin
                    state_d     = ONE;
                    headInstr_d = in_instr;
                    headPc_d    = in_pc;
                end
            end
            ONE: begin
                if (pushFire && popFire) begin
                    headInstr_d = in_instr;
                    headPc_d    = in_pc;
                end else if (pushFire) begin
                    state_d     = FULL;
                    skidInstr_d = in_instr;
                    skidPc_d    = in_pc;
                end else if (popFire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (popFire) begin
                    state_d     = ONE;
                    headInstr_d = skidInstr_q;
                    headPc_d    = skidPc_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // A flushed buffer keeps its stale head so decode-side fields do not toggle while invalid.
        if (flush) begin
            state_d     = EMPTY;
            headInstr_d = headInstr_q;
            headPc_d    = headPc_q;
            skidInstr_d = skidInstr_q;
            skidPc_d    = skidPc_q;
        end
        inReady_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            inReady_q   <= 1'b0;
            headInstr_q <= '0;
            headPc_q    <= '0;
            skidInstr_q <= '0;
            skidPc_q    <= '0;
        end else begin
            state_q     <= state_d;
            inReady_q   <= inReady_d;
            headInstr_q <= headInstr_d;
            headPc_q    <= headPc_d;
            skidInstr_q <= skidInstr_d;
            skidPc_q    <= skidPc_d;
        end
    end

    assign out_opcode  = headInstr_q[15:10];
    assign out_reg_sel = headInstr_q[9];
    assign out_immed   = headInstr_q[IMM_W-1:0];
    assign out_pc      = headPc_q;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed self-checking bench for instr_fetch_buffer.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_instr_fetch_buffer;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_opcode;
    logic        out_reg_sel;
    logic [8:0]  out_immed;
    logic [15:0] out_pc;

    int checkCount;
    int passCount;

    instr_fetch_buffer #(.PC_W(16), .INSTR_W(16), .IMM_W(9)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .in_valid(in_valid),
        .in_instr(in_instr),
        .in_pc(in_pc),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_opcode(out_opcode),
        .out_reg_sel(out_reg_sel),
        .out_immed(out_immed),
        .out_pc(out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic valid, input logic [15:0] instr, input logic [15:0] pc,
                                 input logic ready, input logic fl);
        in_valid  = valid;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = ready;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] signExtend(input logic [8:0] imm);
        return {{7{imm[8]}}, imm};
    endfunction

    logic [15:0] immInstr [4] = '{16'h4000, 16'h4201, 16'h4100, 16'hFFFF};
    logic [5:0]  immOp    [4] = '{6'h10, 6'h10, 6'h10, 6'h3F};
    logic        immSel   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [8:0]  immVal   [4] = '{9'h000, 9'h001, 9'h100, 9'h1FF};
    logic [15:0] immSext  [4] = '{16'h0000, 16'h0001, 16'hFF00, 16'hFFFF};

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst_n = 1'b0;
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Reset state, then single push of A5FF (bit 9 of A5FF is 0)
        tick();
        checkOutput("rst in_ready", in_ready, 0);
        checkOutput("rst out_valid", out_valid, 0);
        checkOutput("rst out_immed", out_immed, 0);
        checkOutput("rst out_pc", out_pc, 0);
        checkOutput("rst out_opcode", out_opcode, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("post-rst in_ready", in_ready, 1);
        checkOutput("post-rst out_valid", out_valid, 0);
        applyStimulus(1'b1, 16'hA5FF, 16'h0010, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        checkOutput("t1 out_valid", out_valid, 1);
        checkOutput("t1 opcode", out_opcode, 6'h29);
        checkOutput("t1 reg_sel", out_reg_sel, 0);
        checkOutput("t1 immed", out_immed, 9'h1FF);
        checkOutput("t1 sext", signExtend(out_immed), 16'hFFFF);
        checkOutput("t1 pc", out_pc, 16'h0010);
        tick();
        checkOutput("t1 drained", out_valid, 0);

        // Back-to-back stream of 8 with decode always ready
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 16'h1000 + 16'(i * 16'h0111), 16'h0100 + 16'(2 * i), 1'b1, 1'b0);
            tick();
            checkOutput("t2 out_valid", out_valid, 1);
            checkOutput("t2 in_ready", in_ready, 1);
            checkOutput("t2 order pc", out_pc, 16'h0100 + 16'(2 * i));
            checkOutput("t2 immed", out_immed, 9'((16'h1000 + 16'(i * 16'h0111)) & 16'h01FF));
        end
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        tick();
        checkOutput("t2 drained", out_valid, 0);

        // Stall until full, third word held off, then drain in order
        applyStimulus(1'b1, 16'h0101, 16'h0200, 1'b0, 1'b0);
        tick();
        checkOutput("t3 one in_ready", in_ready, 1);
        applyStimulus(1'b1, 16'h0202, 16'h0202, 1'b0, 1'b0);
        tick();
        checkOutput("t3 full in_ready", in_ready, 0);
        checkOutput("t3 full head pc", out_pc, 16'h0200);
        applyStimulus(1'b1, 16'h0303, 16'h0204, 1'b0, 1'b0);
        tick();
        checkOutput("t3 hold in_ready", in_ready, 0);
        checkOutput("t3 hold immed", out_immed, 9'h101);
        applyStimulus(1'b1, 16'h0303, 16'h0204, 1'b1, 1'b0);
        tick();
        checkOutput("t3 pop2 immed", out_immed, 9'h002);
        checkOutput("t3 pop2 pc", out_pc, 16'h0202);
        checkOutput("t3 pop2 in_ready", in_ready, 1);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        checkOutput("t3 pop3 immed", out_immed, 9'h103);
        checkOutput("t3 pop3 pc", out_pc, 16'h0204);
        tick();
        checkOutput("t3 drained", out_valid, 0);

        // Flush while full with a simultaneous push of 1234
        applyStimulus(1'b1, 16'h0A0A, 16'h0400, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h0B0B, 16'h0402, 1'b0, 1'b0);
        tick();
        checkOutput("t4 full", in_ready, 0);
        applyStimulus(1'b1, 16'h1234, 16'h0404, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        checkOutput("t4 flush out_valid", out_valid, 0);
        checkOutput("t4 flush in_ready", in_ready, 1);
        tick();
        checkOutput("t4 still empty", out_valid, 0);
        applyStimulus(1'b1, 16'h5555, 16'h0500, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        checkOutput("t4 next pc", out_pc, 16'h0500);
        checkOutput("t4 next immed", out_immed, 9'h155);
        tick();
        checkOutput("t4 drained", out_valid, 0);

        // Asynchronous reset between edges
        applyStimulus(1'b1, 16'h7777, 16'h0600, 1'b0, 1'b0);
        tick();
        checkOutput("t5 pre valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5 async out_valid", out_valid, 0);
        checkOutput("t5 async out_immed", out_immed, 0);
        checkOutput("t5 async in_ready", in_ready, 0);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("t5 rel in_ready", in_ready, 1);
        checkOutput("t5 rel out_valid", out_valid, 0);
        applyStimulus(1'b1, 16'hC003, 16'h0300, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 16'hC004, 16'h0302, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        checkOutput("t5 first pc", out_pc, 16'h0300);
        tick();
        checkOutput("t5 second pc", out_pc, 16'h0302);
        tick();
        checkOutput("t5 drained", out_valid, 0);

        // Immediate field boundaries
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, immInstr[i], 16'h0700 + 16'(2 * i), 1'b1, 1'b0);
            tick();
            checkOutput("t6 opcode", out_opcode, immOp[i]);
            checkOutput("t6 reg_sel", out_reg_sel, immSel[i]);
            checkOutput("t6 immed", out_immed, immVal[i]);
            checkOutput("t6 sext", signExtend(out_immed), immSext[i]);
        end
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        tick();
        checkOutput("t6 drained", out_valid, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
